fib_step_sequencer: RTL and testbench
=====================================

Name: fib_step_sequencer

Overview:
- Controller that drives the step input and clear of the 10-term Fibonacci counter (terms 0,1,1,2,3,5,8,13,21,34).
- Turns three debounced push-buttons into clean single-cycle step and clear pulses.
- Provides a timed auto-run mode with selectable rate.
- Keeps a shadow term index so the top level knows the counter's position without decoding its output.

Parameters:
- DIV_BASE, 16: clk cycles per auto-run step at rate_sel=0.
- PRESC_W, 24: prescaler width; DIV_BASE*8 must be < 2**PRESC_W.
- MAX_INDEX, 9: last term index; the index wraps to 0 after it.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- btn_step, input, 1: debounced, asynchronous level; rising edge requests one step.
- btn_run, input, 1: debounced, asynchronous level; rising edge toggles auto-run.
- btn_clr, input, 1: debounced, asynchronous level; rising edge requests clear.
- rate_sel, input, 2: auto-run period = DIV_BASE << rate_sel (x1, x2, x4, x8); sampled every cycle.
- step_out, output, 1: one-cycle pulse to the counter's step input.
- clr_out, output, 1: one-cycle pulse to the counter's clear.
- index, output, 4: shadow term index, 0..MAX_INDEX.
- running, output, 1: high while in RUN.
- wrap, output, 1: one-cycle pulse, coincident with the step_out that moves index from MAX_INDEX to 0.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, prescaler=0, index=0, synchronizer/edge flops=0. All outputs 0 (step_out, clr_out, index, running, wrap). Reset asserted mid-run aborts immediately; no pending pulse survives.
- Input path:
  - Each button passes through a 2-flop synchronizer plus a rising-edge detector.
  - Buttons sampled high at edge k give an internal request during cycle k+2..k+3.
  - The resulting output pulse (step_out/clr_out) is high during the cycle after edge k+3.
  - Held buttons produce one request only.
- States (all registered outputs):
  - IDLE: step request -> step_out=1 for one cycle, index advances, remain IDLE. Run request -> RUN, prescaler=0, running=1. Clear request -> clr_out=1, index=0.
  - RUN:
    - Prescaler counts 0..period-1. At period-1: step_out=1, index advances, prescaler=0. The first step occurs period cycles after entering RUN.
    - Run request -> IDLE, running=0, prescaler cleared, no step that cycle.
    - Step requests ignored.
    - Clear request -> clr_out=1, index=0, running=0, IDLE.
- Priority, when requests coincide in one cycle: clear > run toggle > step / timer tick.
- rate_sel change in RUN: takes effect immediately. If the prescaler value is already >= the new period-1, a tick fires on the next cycle and the prescaler restarts from 0.
- Index arithmetic: index = (index==MAX_INDEX) ? 0 : index+1 on every step_out. wrap asserts on the MAX_INDEX->0 step.
- step_out and clr_out are never high in the same cycle. step_out is never high in two consecutive cycles.

Optional Feature:
- Macro: FIB_SEQ_STOP_AT_WRAP_EN.
- Defined: in RUN, the step that makes index==MAX_INDEX also forces a return to IDLE (running=0 in the next cycle), so auto-run halts on the last term. Manual steps still wrap.
- Undefined: RUN wraps continuously.

Decomposition:
- Shared package fib_ctrl_pkg:
  - state enum (IDLE, RUN)
  - MAX_INDEX default
  - rate_sel code constants (RATE_X1..RATE_X8)
  - index width constant (4)
- Sub-module btn_edge_sync: 2-flop synchronizer plus rising-edge pulse, reset by reset_n. Instantiated three times.

Test Plan:
- Reset then three btn_step presses (each held 20 cycles) -> exactly three step_out pulses, each 4 cycles after the press is first sampled; index=3; wrap never asserted.
- Ten btn_step presses from index 0 -> the 10th step_out coincides with wrap=1; index=0 afterwards.
- btn_run with rate_sel=0, DIV_BASE=16 -> running=1; step_out at 16, 32, 48 cycles after entry. Toggle again -> running=0 and no further steps.
- In RUN, rate_sel changed 0->3 -> steps spaced 128 cycles. btn_step pulses in RUN -> no extra step_out.
- btn_clr and btn_run rising in the same cycle during RUN at index=6 -> clr_out once, index=0, running=0, no step_out.
- reset_n dropped for 2 cycles mid-RUN at prescaler 10 -> all outputs 0 immediately. After release, IDLE with no spurious pulse. With FIB_SEQ_STOP_AT_WRAP_EN, RUN from index 0 halts with index=9, running=0.

Source files
------------

// File: rtl/fib_ctrl_pkg.sv
// Shared types and constants for the Fibonacci counter step sequencer.
package fib_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    localparam int unsigned IDX_W         = 4;
    localparam int unsigned MAX_INDEX_DEF = 9;
    localparam int unsigned RATE_W        = 2;

    // Auto-run period multipliers applied to DIV_BASE.
    localparam logic [RATE_W-1:0] RATE_X1 = 2'd0;
    localparam logic [RATE_W-1:0] RATE_X2 = 2'd1;
    localparam logic [RATE_W-1:0] RATE_X4 = 2'd2;
    localparam logic [RATE_W-1:0] RATE_X8 = 2'd3;

    // Term index after one step, wrapping past the last term.
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] cur,
                                                     input logic [IDX_W-1:0] last);
        return (cur == last) ? '0 : cur + IDX_W'(1);
    endfunction

endpackage

// File: rtl/fib_step_sequencer_if.sv
// Button/rate inputs and counter-control outputs of the step sequencer.
interface fib_step_sequencer_if;
    import fib_ctrl_pkg::*;

    logic              btn_step;
    logic              btn_run;
    logic              btn_clr;
    logic [RATE_W-1:0] rate_sel;
    logic              step_out;
    logic              clr_out;
    logic [IDX_W-1:0]  index;
    logic              running;
    logic              wrap;

    modport master (
        output btn_step, btn_run, btn_clr, rate_sel,
        input  step_out, clr_out, index, running, wrap
    );

    modport slave (
        input  btn_step, btn_run, btn_clr, rate_sel,
        output step_out, clr_out, index, running, wrap
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// A button sampled high at edge k yields req_o high from edge k+2 to k+3.
module btn_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic req_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic req_q,   req_d;

    // Synchronizer chain and edge detect.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        req_d   = sync2_q & ~prev_q;
    end

    // Pipeline registers, cleared by reset so no stale edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            req_q   <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/fib_step_sequencer.sv
// Step/clear controller for the 10-term Fibonacci counter with timed auto-run.
// Optional build macro FIB_SEQ_STOP_AT_WRAP_EN: auto-run halts when the index
// reaches the last term instead of wrapping continuously.
module fib_step_sequencer
    import fib_ctrl_pkg::*;
#(
    parameter int unsigned DIV_BASE  = 16,
    parameter int unsigned PRESC_W   = 24,
    parameter int unsigned MAX_INDEX = MAX_INDEX_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fib_step_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAX_INDEX);
    localparam logic [PRESC_W-1:0] BASE_CNT = PRESC_W'(DIV_BASE);

    seq_state_e         state_q,   state_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [IDX_W-1:0]   index_q,   index_d;
    logic               step_q,    step_d;
    logic               clr_q,     clr_d;
    logic               wrap_q,    wrap_d;
    logic               running_q, running_d;

    logic               req_step;
    logic               req_run;
    logic               req_clr;
    logic [PRESC_W-1:0] period_m1;
    logic               tick;

    btn_edge_sync u_sync_step (.clk(clk), .reset_n(reset_n), .btn_i(bus.btn_step), .req_o(req_step));
    btn_edge_sync u_sync_run  (.clk(clk), .reset_n(reset_n), .btn_i(bus.btn_run),  .req_o(req_run));
    btn_edge_sync u_sync_clr  (.clk(clk), .reset_n(reset_n), .btn_i(bus.btn_clr),  .req_o(req_clr));

    // Live period from rate_sel; >= lets a shortened period fire immediately.
    always_comb begin
        period_m1 = (BASE_CNT << bus.rate_sel) - PRESC_W'(1);
        tick      = (presc_q >= period_m1);
    end

    // Next state and registered outputs; priority clear > run toggle > step/tick.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        index_d = index_q;
        step_d  = 1'b0;
        clr_d   = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (req_clr) begin
                    clr_d   = 1'b1;
                    index_d = '0;
                end else if (req_run) begin
                    state_d = ST_RUN;
                end else if (req_step && !step_q) begin
                    // Guard keeps step_out from doubling right after a halting tick.
                    step_d  = 1'b1;
                    wrap_d  = (index_q == LAST_IDX);
                    index_d = next_index(index_q, LAST_IDX);
                end
            end
            ST_RUN: begin
                if (req_clr) begin
                    clr_d   = 1'b1;
                    index_d = '0;
                    presc_d = '0;
                    state_d = ST_IDLE;
                end else if (req_run) begin
                    presc_d = '0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    step_d  = 1'b1;
                    wrap_d  = (index_q == LAST_IDX);
                    index_d = next_index(index_q, LAST_IDX);
                    presc_d = '0;
`ifdef FIB_SEQ_STOP_AT_WRAP_EN
                    if (index_d == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            index_q   <= '0;
            step_q    <= 1'b0;
            clr_q     <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            index_q   <= index_d;
            step_q    <= step_d;
            clr_q     <= clr_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign bus.step_out = step_q;
    assign bus.clr_out  = clr_q;
    assign bus.index    = index_q;
    assign bus.running  = running_q;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_fib_step_sequencer.sv
// Self-checking bench for fib_step_sequencer: directed scenarios plus random
// button activity, checked every cycle against a behavioural model.
module tb_fib_step_sequencer;
    import fib_ctrl_pkg::*;

    localparam int DIV  = 16;
    localparam int LAST = 9;

    logic clk = 1'b0;
    logic reset_n;

    fib_step_sequencer_if bus_if ();

    fib_step_sequencer #(
        .DIV_BASE (16),
        .PRESC_W  (24),
        .MAX_INDEX(9)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: button sample history and controller state.
    logic [4:1] hs, hr, hc;
    int m_idx, m_cnt;
    bit m_run, m_step, m_clr, m_wrap;

    always @(posedge clk or negedge reset_n) begin : model
        int idx, cnt, period;
        bit run, rs, rr, rc, st, cl, wr;
        if (!reset_n) begin
            hs <= '0; hr <= '0; hc <= '0;
            m_idx <= 0; m_cnt <= 0; m_run <= 0;
            m_step <= 0; m_clr <= 0; m_wrap <= 0;
        end else begin
            // A level first sampled high three edges ago is a request now.
            rs = hs[3] & ~hs[4];
            rr = hr[3] & ~hr[4];
            rc = hc[3] & ~hc[4];
            period = DIV << bus_if.rate_sel;
            idx = m_idx; cnt = m_cnt; run = m_run;
            st = 0; cl = 0; wr = 0;
            if (rc) begin
                cl = 1; idx = 0; run = 0; cnt = 0;
            end else if (rr) begin
                run = !run; cnt = 0;
            end else if (run) begin
                if (cnt >= period - 1) begin st = 1; cnt = 0; end
                else cnt = cnt + 1;
            end else if (rs && !m_step) begin
                st = 1;
            end
            if (st) begin
                wr  = (idx == LAST);
                idx = wr ? 0 : idx + 1;
`ifdef FIB_SEQ_STOP_AT_WRAP_EN
                if (run && idx == LAST) run = 0;
`endif
            end
            hs <= {hs[3:1], bus_if.btn_step};
            hr <= {hr[3:1], bus_if.btn_run};
            hc <= {hc[3:1], bus_if.btn_clr};
            m_idx <= idx; m_cnt <= cnt; m_run <= run;
            m_step <= st; m_clr <= cl; m_wrap <= wr;
        end
    end

    int cyc = 0;
    int step_cnt = 0, clr_cnt = 0, wrap_cnt = 0;
    int last_step_cyc = 0, last_wrap_cyc = -1, entry_cyc = 0, press_cyc = 0;
    int step_q[$];
    bit prev_step = 0, prev_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle, compare against the model, and log output events.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("step_out", 32'(bus_if.step_out), 32'(m_step));
        chk("clr_out",  32'(bus_if.clr_out),  32'(m_clr));
        chk("wrap",     32'(bus_if.wrap),     32'(m_wrap));
        chk("running",  32'(bus_if.running),  32'(m_run));
        chk("index",    32'(bus_if.index),    32'(m_idx));
        chk("step_clr_exclusive", 32'(bus_if.step_out & bus_if.clr_out), 0);
        chk("step_back_to_back",  32'(prev_step & bus_if.step_out), 0);
        prev_step = (bus_if.step_out === 1'b1);
        if (bus_if.step_out === 1'b1) begin
            step_cnt++; last_step_cyc = cyc; step_q.push_back(cyc);
        end
        if (bus_if.wrap === 1'b1) begin wrap_cnt++; last_wrap_cyc = cyc; end
        if (bus_if.clr_out === 1'b1) clr_cnt++;
        if (bus_if.running === 1'b1 && !prev_run) entry_cyc = cyc;
        prev_run = (bus_if.running === 1'b1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // which: 0 = step, 1 = run, 2 = clear
    task automatic press(input int which, input int hold, input int gap);
        case (which)
            0: bus_if.btn_step = 1'b1;
            1: bus_if.btn_run  = 1'b1;
            default: bus_if.btn_clr = 1'b1;
        endcase
        press_cyc = cyc;
        ticks(hold);
        bus_if.btn_step = 1'b0;
        bus_if.btn_run  = 1'b0;
        bus_if.btn_clr  = 1'b0;
        ticks(gap);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int s0, c0, w0;
        bit found;
        reset_n = 1'b0;
        bus_if.btn_step = 1'b0;
        bus_if.btn_run  = 1'b0;
        bus_if.btn_clr  = 1'b0;
        bus_if.rate_sel = RATE_X1;
        ticks(3);
        chk("reset_index",   32'(bus_if.index), 0);
        chk("reset_running", 32'(bus_if.running), 0);
        chk("reset_step",    32'(bus_if.step_out), 0);
        reset_n = 1'b1;
        ticks(4);

        // Three manual steps, each held 20 cycles.
        s0 = step_cnt; w0 = wrap_cnt;
        for (int i = 0; i < 3; i++) begin
            press(0, 20, 5);
            chk("step_latency", 32'(last_step_cyc - press_cyc), 4);
        end
        chk("three_steps", 32'(step_cnt - s0), 3);
        chk("index_after_3", 32'(bus_if.index), 3);
        chk("no_wrap_3", 32'(wrap_cnt - w0), 0);

        // Clear then ten quick presses: tenth step wraps.
        c0 = clr_cnt;
        press(2, 3, 4);
        chk("clear_pulse", 32'(clr_cnt - c0), 1);
        chk("index_cleared", 32'(bus_if.index), 0);
        w0 = wrap_cnt; s0 = step_cnt;
        for (int i = 0; i < 10; i++) press(0, 3, 3);
        ticks(3);
        chk("ten_steps", 32'(step_cnt - s0), 10);
        chk("wrap_once", 32'(wrap_cnt - w0), 1);
        chk("wrap_with_step", 32'(last_wrap_cyc), 32'(last_step_cyc));
        chk("index_after_wrap", 32'(bus_if.index), 0);

        // Auto-run at x1: steps 16, 32, 48 cycles after entry, then stop.
        bus_if.rate_sel = RATE_X1;
        step_q.delete();
        press(1, 3, 0);
        ticks(55);
        chk("run_active", 32'(bus_if.running), 1);
        chk("run_x1_count", 32'(step_q.size()), 3);
        if (step_q.size() == 3)
            for (int i = 0; i < 3; i++)
                chk("run_x1_time", 32'(step_q[i] - entry_cyc), 32'(16 * (i + 1)));
        press(1, 3, 2);
        s0 = step_cnt;
        ticks(100);
        chk("run_stopped", 32'(bus_if.running), 0);
        chk("no_steps_after_stop", 32'(step_cnt - s0), 0);

        // Auto-run, switch to x8, manual presses ignored, then drop back to x1.
        press(1, 3, 0);
        ticks(20);
        bus_if.rate_sel = RATE_X8;
        step_q.delete();
        ticks(100);
        for (int i = 0; i < 3; i++) press(0, 3, 3);
        ticks(200);
        chk("run_x8_count", 32'(step_q.size() >= 2), 1);
        if (step_q.size() >= 2)
            chk("run_x8_spacing", 32'(step_q[1] - step_q[0]), 128);
        bus_if.rate_sel = RATE_X1;
        ticks(40);
        press(1, 3, 6);

        // Clear and run toggle together in RUN at index 6.
        press(2, 3, 3);
        for (int i = 0; i < 5; i++) press(0, 3, 3);
        press(1, 3, 0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (bus_if.index === 4'd6) found = 1;
        end
        chk("reach_index6", 32'(found), 1);
        c0 = clr_cnt; s0 = step_cnt;
        bus_if.btn_clr = 1'b1;
        bus_if.btn_run = 1'b1;
        ticks(3);
        bus_if.btn_clr = 1'b0;
        bus_if.btn_run = 1'b0;
        ticks(10);
        chk("coinc_clear_once", 32'(clr_cnt - c0), 1);
        chk("coinc_no_step", 32'(step_cnt - s0), 0);
        chk("coinc_index", 32'(bus_if.index), 0);
        chk("coinc_idle", 32'(bus_if.running), 0);

        // Reset asserted mid-run around prescaler 10.
        press(0, 3, 3);
        press(1, 3, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus_if.running === 1'b1) found = 1;
            else tick();
        end
        chk("reach_run", 32'(found), 1);
        ticks(10);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_step",    32'(bus_if.step_out), 0);
        chk("rst_clr",     32'(bus_if.clr_out), 0);
        chk("rst_index",   32'(bus_if.index), 0);
        chk("rst_running", 32'(bus_if.running), 0);
        chk("rst_wrap",    32'(bus_if.wrap), 0);
        ticks(2);
        reset_n = 1'b1;
        s0 = step_cnt; c0 = clr_cnt;
        ticks(30);
        chk("post_rst_no_step", 32'(step_cnt - s0), 0);
        chk("post_rst_no_clr",  32'(clr_cnt - c0), 0);
        chk("post_rst_idle",    32'(bus_if.running), 0);

        // Long auto-run from index 0.
        w0 = wrap_cnt;
        press(1, 3, 0);
        ticks(180);
`ifdef FIB_SEQ_STOP_AT_WRAP_EN
        chk("halt_index", 32'(bus_if.index), 9);
        chk("halt_idle",  32'(bus_if.running), 0);
`else
        chk("cont_wrap",    32'(wrap_cnt - w0), 1);
        chk("cont_running", 32'(bus_if.running), 1);
        press(1, 3, 6);
`endif

        // Random button and rate activity.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(5) == 0)   bus_if.btn_step = ~bus_if.btn_step;
            if ($urandom_range(39) == 0)  bus_if.btn_run  = ~bus_if.btn_run;
            if ($urandom_range(99) == 0)  bus_if.btn_clr  = ~bus_if.btn_clr;
            if ($urandom_range(199) == 0) bus_if.rate_sel = 2'($urandom_range(3));
            tick();
        end
        bus_if.btn_step = 1'b0;
        bus_if.btn_run  = 1'b0;
        bus_if.btn_clr  = 1'b0;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
